sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial transmitter for the sync-pattern bit stream consumed by the team's Moore "1011" sequence detector. It accepts a parallel payload word through a valid/ready handshake. It then emits one bit per clock: a PAT_W-bit sync preamble (default 1011) followed by the payload, both MSB first, and then a programmable idle gap. It sits on the transmit side of the single-bit serial link that feeds the detector.

Parameters:
DATA_W, 8, payload width in bits (>=1)
PAT_W, 4, sync preamble width in bits (>=1)
PATTERN, 4'b1011, sync preamble value, sent MSB first
GAP, 2, idle cycles (sequence_out=0) forced after each payload (>=0)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_W  payload word, sampled when data_valid && data_ready
data_valid  input  1  payload available
data_ready  output  1  high only in IDLE; asserted while reset is high
sequence_out  output  1  registered serial bit stream; 0 when not transmitting
frame_active  output  1  registered; high on every cycle that sequence_out carries a preamble or payload bit
done  output  1  registered single-cycle pulse, coincident with the last payload bit on sequence_out

Behaviour:
- One clock (clock); reset is asynchronous and active-high.
- Reset values: state=IDLE, sequence_out=0, frame_active=0, done=0, counters=0, shift register=0, data_ready=1.
- Reset mid-frame aborts the frame immediately (asynchronous). Remaining bits are discarded and not resumed.
- FSM states: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE:
  - data_ready=1.
  - On data_valid && data_ready at edge N: latch data_in into the shift register, load bit counter = PAT_W-1, go to PREAMBLE.
  - Otherwise stay in IDLE with sequence_out=0.
- PREAMBLE:
  - sequence_out at cycle N+1 = PATTERN[PAT_W-1], then descending bits one per cycle.
  - After PATTERN[0] is driven, go to PAYLOAD with counter = DATA_W-1.
- PAYLOAD:
  - Drives data_in[DATA_W-1] first, down to data_in[0].
  - done=1 on the cycle data_in[0] is driven.
  - Next state is GAP if GAP>0, else IDLE.
- GAP: sequence_out=0, frame_active=0 for exactly GAP cycles, then IDLE.
- Latency and spacing:
  - First preamble bit appears 1 cycle after the accepting edge.
  - A frame occupies PAT_W+DATA_W consecutive cycles with frame_active=1.
  - data_ready is low from the cycle after acceptance until return to IDLE.
  - Minimum spacing between accept edges is PAT_W+DATA_W+GAP+1 cycles.
- data_in changes and data_valid toggles outside IDLE are ignored. The word is captured once at acceptance.
- data_valid held high continuously gives back-to-back frames separated by GAP zero cycles plus one IDLE cycle.
- The payload is not bit-stuffed. Payload bits that contain the pattern may cause downstream false detections; framing is owned by the upper layer.
- Counter width is $clog2(max(PAT_W,DATA_W,GAP,2)). The counter never wraps in normal operation; it is reloaded on every state entry.

Decomposition:
- Shared package seq_pkg:
  - state encoding enum (IDLE/PREAMBLE/PAYLOAD/GAP)
  - default PATTERN=4'b1011 and PAT_W=4 constants, also used by the detector bench
- One natural sub-module, piso_shift: loadable parallel-in/serial-out register with MSB-first shift enable.
- FSM and counter stay in the top module.

Test Plan:
- Reset then idle, data_valid=0 for 20 cycles -> data_ready=1, sequence_out=0, frame_active=0, done=0 throughout.
- Single frame, data_in=8'hA5 accepted at cycle 0 with GAP=2 -> sequence_out cycles 1..12 = 1011_10100101; frame_active=1 on cycles 1..12; done=1 only on cycle 12; zeros on 13..14; data_ready=1 again at cycle 15.
- data_valid held high with data_in=8'h00 then 8'hFF -> second accept exactly 15 cycles after the first; second stream = 1011_11111111; data_in changes mid-frame have no effect.
- Asynchronous reset asserted during payload bit 3 -> sequence_out, frame_active, done drop to 0 immediately; after release data_ready=1 and the next frame starts with a full preamble.
- Loopback into the 1011 detector with data_in=8'h00, GAP=0 -> detector_out asserted exactly once per frame, one cycle after the 4th preamble bit.
- Parameter sweep DATA_W=1, PAT_W=1 (PATTERN=1'b1), GAP=0 -> frame = 2 bits; done on the 2nd bit; re-accept possible 3 cycles after the previous accept.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sync-pattern serial link: FSM state encoding and
// the default preamble, which the detector bench also uses.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } seq_state_t;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage : seq_pkg

// File: rtl/sequence_generator_piso_shift.sv
// Loadable parallel-in/serial-out register; the MSB is the next bit to send
// and each shift enable moves the following bit into the MSB position.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift_en) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[DATA_W-1];

endmodule : piso_shift

// File: rtl/sequence_generator.sv
// Serial transmitter: sync preamble then payload, both MSB first, followed by
// a fixed idle gap. All serial outputs are registered from next-state logic.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               GAP     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              sequence_out,
  output logic              frame_active,
  output logic              done
);

  localparam int M1    = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int M2    = (M1 > GAP) ? M1 : GAP;
  localparam int M3    = (M2 > 2) ? M2 : 2;
  localparam int CNT_W = $clog2(M3);
  localparam int GAP_N = (GAP > 0) ? GAP : 1;

  localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_N - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             seq_q, seq_d;
  logic             fa_q, fa_d;
  logic             done_q, done_d;
  logic             load, shift_en, sr_msb, pat_bit;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .din      (data_in),
    .msb      (sr_msb)
  );

  assign cnt_dec = cnt_q - CNT_W'(1);

  // Preamble bit that goes out on the cycle after this edge.
  always_comb begin
    pat_bit = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (cnt_dec == CNT_W'(i)) pat_bit = PATTERN[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seq_d    = 1'b0;
    fa_d     = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          load    = 1'b1;
          state_d = ST_PREAMBLE;
          cnt_d   = PAT_LAST;
          seq_d   = PATTERN[PAT_W-1];
          fa_d    = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        fa_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = ST_PAYLOAD;
          cnt_d    = DATA_LAST;
          seq_d    = sr_msb;
          shift_en = 1'b1;
          done_d   = (DATA_W == 1);
        end else begin
          cnt_d = cnt_dec;
          seq_d = pat_bit;
        end
      end
      ST_PAYLOAD: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fa_d     = 1'b1;
          seq_d    = sr_msb;
          shift_en = 1'b1;
          cnt_d    = cnt_dec;
          done_d   = (cnt_dec == '0);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seq_q   <= 1'b0;
      fa_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      fa_q    <= fa_d;
      done_q  <= done_d;
    end
  end

  assign data_ready   = (state_q == ST_IDLE);
  assign sequence_out = seq_q;
  assign frame_active = fa_q;
  assign done         = done_q;

endmodule : sequence_generator

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: default build plus a 1-bit/1-bit/no-gap build.
module tb_sequence_generator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, sequence_out, frame_active, done;

  logic [0:0] s_data = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_seq, s_fa, s_done;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  sequence_generator u_dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .sequence_out (sequence_out),
    .frame_active (frame_active),
    .done         (done)
  );

  sequence_generator #(
    .DATA_W (1),
    .PAT_W  (1),
    .PATTERN(1'b1),
    .GAP    (0)
  ) u_small (
    .clock        (clock),
    .reset        (reset),
    .data_in      (s_data),
    .data_valid   (s_valid),
    .data_ready   (s_ready),
    .sequence_out (s_seq),
    .frame_active (s_fa),
    .done         (s_done)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       rdy;
    logic       seq;
    logic       fa;
    logic       dn;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int cyc, input logic rdy,
                          input logic seq, input logic fa, input logic dn);
    chk({tag, ".data_ready"},   cyc, 32'(data_ready),   32'(rdy));
    chk({tag, ".sequence_out"}, cyc, 32'(sequence_out), 32'(seq));
    chk({tag, ".frame_active"}, cyc, 32'(frame_active), 32'(fa));
    chk({tag, ".done"},         cyc, 32'(done),         32'(dn));
  endtask

  initial begin
    logic [15:0] e_seq, e_fa, e_dn, e_rdy;
    logic [27:0] b_seq, b_fa, b_dn, b_rdy;
    logic [6:0]  s_eseq, s_efa, s_edn, s_erdy;
    logic [3:0]  pat;
    logic [3:0]  hist;
    int          det_cnt, det_cyc;

    // Reset held: outputs quiet, ready asserted.
    repeat (2) @(negedge clock);
    chk_main("in_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Idle with no valid for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk_main("idle", c, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Single A5 frame, cycle 0 is the accepting cycle.
    e_seq = 16'b0_1011_10100101_00_0;
    e_fa  = 16'b0_1111_11111111_00_0;
    e_dn  = 16'b0_0000_00000001_00_0;
    e_rdy = 16'b1_0000_00000000_00_1;
    for (int i = 0; i < 16; i++) begin
      tbl[i].valid = (i == 0) || (i >= 3 && i <= 10);
      tbl[i].data  = (i == 0) ? 8'hA5 : 8'h5A;
      tbl[i].rdy   = e_rdy[15-i];
      tbl[i].seq   = e_seq[15-i];
      tbl[i].fa    = e_fa[15-i];
      tbl[i].dn    = e_dn[15-i];
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk_main("frame_a5", i, tbl[i].rdy, tbl[i].seq, tbl[i].fa, tbl[i].dn);
      data_valid = tbl[i].valid;
      data_in    = tbl[i].data;
    end
    data_valid = 1'b0;
    repeat (2) @(negedge clock);

    // Back-to-back with valid held: 8'h00 then 8'hFF, data changed mid-frame.
    b_seq = 28'b0_1011_00000000_00_0_1011_11111111;
    b_fa  = 28'b0_1111_11111111_00_0_1111_11111111;
    b_dn  = 28'b0_0000_00000001_00_0_0000_00000001;
    b_rdy = 28'b1_0000_00000000_00_1_0000_00000000;
    hist = 4'b0000;
    det_cnt = 0;
    det_cyc = -1;
    for (int c = 0; c < 28; c++) begin
      @(negedge clock);
      chk_main("b2b", c, b_rdy[27-c], b_seq[27-c], b_fa[27-c], b_dn[27-c]);
      if (c >= 1 && c <= 14) begin
        hist = {hist[2:0], sequence_out};
        if (hist == 4'b1011) begin
          det_cnt++;
          det_cyc = c;
        end
      end
      if (c == 0) begin
        data_valid = 1'b1;
        data_in    = 8'h00;
      end
      if (c == 3) data_in = 8'hFF;
    end
    data_valid = 1'b0;
    chk("pattern_hits_in_zero_frame", 14, 32'(det_cnt), 32'd1);
    chk("pattern_hit_cycle", 14, 32'(det_cyc), 32'd4);
    repeat (4) @(negedge clock);

    // Asynchronous reset during payload bit 3.
    @(negedge clock);
    data_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (8) @(negedge clock);
    chk_main("pre_abort", 9, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_main("abort", 9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_main("after_abort", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b1;
    data_in    = 8'h3C;
    pat = 4'b1011;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      data_valid = 1'b0;
      chk_main("restart_preamble", k, 1'b0, pat[4-k], 1'b1, 1'b0);
    end
    repeat (16) @(negedge clock);

    // Minimal build: 2-bit frames, re-accept every 3 cycles.
    s_eseq = 7'b0110100;
    s_efa  = 7'b0110110;
    s_edn  = 7'b0010010;
    s_erdy = 7'b1001001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      chk("small.data_ready",   c, 32'(s_ready), 32'(s_erdy[6-c]));
      chk("small.sequence_out", c, 32'(s_seq),   32'(s_eseq[6-c]));
      chk("small.frame_active", c, 32'(s_fa),    32'(s_efa[6-c]));
      chk("small.done",         c, 32'(s_done),  32'(s_edn[6-c]));
      if (c == 0) begin
        s_valid = 1'b1;
        s_data  = 1'b1;
      end
      if (c == 1) s_data = 1'b0;
      if (c == 6) s_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_sequence_generator
